// File: rtl/dice_pool_sequencer.sv
// Drives a dice_roller through an N-die pool and accumulates sum, minimum and maximum.
// Flags samples outside the selected die's legal range and strobes done when the pool ends.
module dice_pool_sequencer #(
    parameter int unsigned ROLL_LATENCY = 2,
    parameter int unsigned SUM_W        = 9
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [3:0]       i_num_dice,
    input  logic [1:0]       i_die_type,
    input  logic             i_abort,
    output logic             o_roll,
    output logic [1:0]       o_die_select,
    input  logic [7:0]       i_rolled_number,
    output logic             o_busy,
    output logic             o_done,
    output logic [SUM_W-1:0] o_total,
    output logic [7:0]       o_min_roll,
    output logic [7:0]       o_max_roll,
    output logic             o_range_err
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDone
    } state_t;

    // One extra bit above the wider operand so the add can never wrap before saturation.
    localparam int unsigned            ACC_W   = ((SUM_W > 8) ? SUM_W : 8) + 1;
    localparam logic [ACC_W-1:0]       SUM_MAX = ACC_W'({SUM_W{1'b1}});
    localparam logic [3:0]             LAT_LD  = 4'(ROLL_LATENCY);

    state_t           r_state;
    state_t           w_state_next;
    logic [3:0]       r_num_dice;
    logic [1:0]       r_die_select;
    logic [3:0]       r_wait_cnt;
    logic [3:0]       r_sample_cnt;
    logic [SUM_W-1:0] r_total;
    logic [7:0]       r_min_roll;
    logic [7:0]       r_max_roll;
    logic             r_range_err;

    logic             w_accept;
    logic             w_sample;
    logic             w_last;
    logic [3:0]       w_sample_cnt_inc;
    logic [7:0]       w_die_max;
    logic             w_out_of_range;
    logic [ACC_W-1:0] w_sum_wide;
    logic [SUM_W-1:0] w_sum_sat;

    assign w_accept         = (r_state == StIdle) && i_start && (i_num_dice != 4'd0);
    // Abort wins over a sample landing in the same cycle.
    assign w_sample         = (r_state == StWait) && (r_wait_cnt == 4'd1) && !i_abort;
    assign w_sample_cnt_inc = r_sample_cnt + 4'd1;
    assign w_last           = w_sample && (w_sample_cnt_inc == r_num_dice);

    always_comb begin
        w_die_max = 8'd4;
        unique case (r_die_select)
            2'b00:   w_die_max = 8'd4;
            2'b01:   w_die_max = 8'd6;
            2'b10:   w_die_max = 8'd8;
            2'b11:   w_die_max = 8'd20;
            default: w_die_max = 8'd4;
        endcase
    end

    assign w_out_of_range = (i_rolled_number == 8'd0) || (i_rolled_number > w_die_max);

    always_comb begin
        w_sum_wide = ACC_W'(r_total) + ACC_W'(i_rolled_number);
        w_sum_sat  = w_sum_wide[SUM_W-1:0];
        if (w_sum_wide > SUM_MAX) begin
            w_sum_sat = SUM_MAX[SUM_W-1:0];
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_next = StReq;
                end
            end
            StReq: begin
                w_state_next = i_abort ? StIdle : StWait;
            end
            StWait: begin
                if (i_abort) begin
                    w_state_next = StIdle;
                end else if (w_sample) begin
                    w_state_next = w_last ? StDone : StReq;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_comb begin
        o_roll = 1'b0;
        o_busy = 1'b0;
        o_done = 1'b0;
        unique case (r_state)
            StReq: begin
                o_roll = 1'b1;
                o_busy = 1'b1;
            end
            StWait: begin
                o_busy = 1'b1;
            end
            StDone: begin
                o_done = 1'b1;
            end
            default: begin
                o_roll = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_num_dice   <= 4'd0;
            r_die_select <= 2'b00;
            r_wait_cnt   <= 4'd0;
            r_sample_cnt <= 4'd0;
            r_total      <= '0;
            r_min_roll   <= 8'hFF;
            r_max_roll   <= 8'h00;
            r_range_err  <= 1'b0;
        end else begin
            r_state <= w_state_next;

            if (w_accept) begin
                r_num_dice   <= i_num_dice;
                r_die_select <= i_die_type;
                r_sample_cnt <= 4'd0;
                r_total      <= '0;
                r_min_roll   <= 8'hFF;
                r_max_roll   <= 8'h00;
                r_range_err  <= 1'b0;
            end

            if (r_state == StReq) begin
                r_wait_cnt <= LAT_LD;
            end else if ((r_state == StWait) && (r_wait_cnt != 4'd0)) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end

            // Out-of-range samples are still folded into the statistics.
            if (w_sample) begin
                r_sample_cnt <= w_sample_cnt_inc;
                r_total      <= w_sum_sat;
                if (i_rolled_number < r_min_roll) begin
                    r_min_roll <= i_rolled_number;
                end
                if (i_rolled_number > r_max_roll) begin
                    r_max_roll <= i_rolled_number;
                end
                if (w_out_of_range) begin
                    r_range_err <= 1'b1;
                end
            end
        end
    end

    assign o_die_select = r_die_select;
    assign o_total      = r_total;
    assign o_min_roll   = r_min_roll;
    assign o_max_roll   = r_max_roll;
    assign o_range_err  = r_range_err;

endmodule

// File: tb/tb_dice_pool_sequencer.sv
// Bench for dice_pool_sequencer: directed pool table, corner sequences and random pools
// checked against a pool-level model; a second instance with an 8-bit total covers saturation.
module tb_dice_pool_sequencer;

    localparam int L = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [3:0] num_dice;
    logic [1:0] die_type;
    logic [7:0] rolled;

    logic       roll, busy, done, range_err;
    logic [1:0] dsel;
    logic [8:0] total;
    logic [7:0] min_roll, max_roll;

    logic       roll8, busy8, done8, range_err8;
    logic [1:0] dsel8;
    logic [7:0] total8, min8, max8;

    dice_pool_sequencer #(.ROLL_LATENCY(L), .SUM_W(9)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_num_dice(num_dice),
        .i_die_type(die_type), .i_abort(abort), .o_roll(roll), .o_die_select(dsel),
        .i_rolled_number(rolled), .o_busy(busy), .o_done(done), .o_total(total),
        .o_min_roll(min_roll), .o_max_roll(max_roll), .o_range_err(range_err)
    );

    dice_pool_sequencer #(.ROLL_LATENCY(L), .SUM_W(8)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_num_dice(num_dice),
        .i_die_type(die_type), .i_abort(abort), .o_roll(roll8), .o_die_select(dsel8),
        .i_rolled_number(rolled), .o_busy(busy8), .o_done(done8), .o_total(total8),
        .o_min_roll(min8), .o_max_roll(max8), .o_range_err(range_err8)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        int           n;
        int           dt;
        logic [119:0] v;
        int           e_tot;
        int           e_tot8;
        int           e_min;
        int           e_max;
        int           e_err;
    } vec_t;

    vec_t             tbl[3];
    byte unsigned     vals[$];
    int               roll_cnt = 0;
    int               n_tests  = 0;
    int               n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance one cycle; acts as the dice_roller, presenting the next value after each roll.
    task automatic tick();
        @(posedge clk);
        #1;
        if (roll) begin
            roll_cnt++;
            if (vals.size() > 0) rolled = vals.pop_front();
            else rolled = 8'd1;
        end
    endtask

    function automatic int die_max(input int dt);
        case (dt)
            0: return 4;
            1: return 6;
            2: return 8;
            default: return 20;
        endcase
    endfunction

    task automatic run_pool(input string tag, input int n, input int dt, input bit poke,
                            input int e_tot, input int e_tot8, input int e_min,
                            input int e_max, input int e_err);
        int lat;
        lat      = n * (L + 1) + 1;
        start    = 1'b1;
        num_dice = 4'(n);
        die_type = 2'(dt);
        tick();
        start = 1'b0;
        for (int t = 1; t <= lat; t++) begin
            if (t > 1) tick();
            chk($sformatf("%s roll t=%0d", tag, t), roll,
                (t < lat) && (((t - 1) % (L + 1)) == 0));
            chk($sformatf("%s busy t=%0d", tag, t), busy, t < lat);
            chk($sformatf("%s done t=%0d", tag, t), done, t == lat);
            chk($sformatf("%s done8 t=%0d", tag, t), done8, t == lat);
            chk($sformatf("%s dsel t=%0d", tag, t), dsel, dt);
            if (poke && t == 4) start = 1'b0;
            if (poke && (t == 3 || t == lat)) begin
                start    = 1'b1;
                num_dice = 4'((n % 15) + 1);
                die_type = 2'(~dt);
            end
        end
        chk({tag, " total"}, total, e_tot);
        chk({tag, " total8"}, total8, e_tot8);
        chk({tag, " min"}, min_roll, e_min);
        chk({tag, " max"}, max_roll, e_max);
        chk({tag, " range_err"}, range_err, e_err);
        tick();
        start = 1'b0;
        chk({tag, " busy after"}, busy, 0);
        chk({tag, " done after"}, done, 0);
        chk({tag, " total hold"}, total, e_tot);
        chk({tag, " dsel hold"}, dsel, dt);
    endtask

    initial begin
        int n, dt, mx, v, tot, mn, mxv, err;
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        num_dice = 4'd0;
        die_type = 2'd0;
        rolled   = 8'd0;

        tbl[0] = '{"3d6", 3, 1, {8'd6, 8'd5, 8'd2}, 13, 13, 2, 6, 0};
        tbl[1] = '{"15d20", 15, 3, {15{8'd20}}, 300, 255, 20, 20, 0};
        tbl[2] = '{"2d4err", 2, 0, {8'd0, 8'd5}, 5, 5, 0, 5, 1};

        tick();
        tick();
        chk("reset roll", roll, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset total", total, 0);
        chk("reset min", min_roll, 8'hFF);
        chk("reset max", max_roll, 0);
        chk("reset range_err", range_err, 0);
        chk("reset dsel", dsel, 0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("idle done c=%0d", i), done, 0);
            chk($sformatf("idle roll c=%0d", i), roll, 0);
        end

        for (int k = 0; k < 3; k++) begin
            vals.delete();
            for (int i = 0; i < tbl[k].n; i++) vals.push_back(tbl[k].v[8*i +: 8]);
            run_pool(tbl[k].name, tbl[k].n, tbl[k].dt, 1'b0, tbl[k].e_tot, tbl[k].e_tot8,
                     tbl[k].e_min, tbl[k].e_max, tbl[k].e_err);
        end

        // Next accepted start clears the sticky error.
        vals.delete();
        vals.push_back(8'd3);
        run_pool("clear_err", 1, 0, 1'b1, 3, 3, 3, 3, 0);

        // start with num_dice=0 is ignored.
        roll_cnt = 0;
        start    = 1'b1;
        num_dice = 4'd0;
        die_type = 2'd2;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("zero busy", busy, 0);
            chk("zero done", done, 0);
        end
        chk("zero roll count", roll_cnt, 0);
        chk("zero total hold", total, 3);
        chk("zero dsel hold", dsel, 0);

        // Abort during WAIT of the second die in a 4-die pool.
        vals.delete();
        vals.push_back(8'd3);
        vals.push_back(8'd4);
        vals.push_back(8'd4);
        vals.push_back(8'd4);
        roll_cnt = 0;
        start    = 1'b1;
        num_dice = 4'd4;
        die_type = 2'd1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("abort pre busy", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort roll", roll, 0);
        chk("abort total", total, 3);
        chk("abort min", min_roll, 3);
        chk("abort max", max_roll, 3);
        chk("abort roll count", roll_cnt, 2);
        vals.delete();
        vals.push_back(8'd7);
        vals.push_back(8'd8);
        run_pool("after_abort", 2, 2, 1'b0, 15, 15, 7, 8, 0);

        // Reset in the middle of a pool.
        vals.delete();
        repeat (3) vals.push_back(8'd5);
        start    = 1'b1;
        num_dice = 4'd3;
        die_type = 2'd1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("midrst pre roll", roll, 1);
        chk("midrst pre total", total, 5);
        rst = 1'b1;
        tick();
        chk("midrst roll", roll, 0);
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst total", total, 0);
        chk("midrst total8", total8, 0);
        chk("midrst min", min_roll, 8'hFF);
        chk("midrst max", max_roll, 0);
        chk("midrst range_err", range_err, 0);
        chk("midrst dsel", dsel, 0);
        rst = 1'b0;
        tick();

        // Random pools against the pool-level model.
        for (int r = 0; r < 25; r++) begin
            n   = $urandom_range(1, 15);
            dt  = $urandom_range(0, 3);
            mx  = die_max(dt);
            tot = 0;
            mn  = 255;
            mxv = 0;
            err = 0;
            vals.delete();
            for (int i = 0; i < n; i++) begin
                v = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 30) : $urandom_range(1, mx);
                vals.push_back(8'(v));
                tot += v;
                if (v < mn) mn = v;
                if (v > mxv) mxv = v;
                if (v == 0 || v > mx) err = 1;
            end
            run_pool($sformatf("rand%0d", r), n, dt, $urandom_range(0, 1) == 1,
                     (tot > 511) ? 511 : tot, (tot > 255) ? 255 : tot, mn, mxv, err);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
